// File: rtl/nv_nvdla_cdma_wt_rsp_seq_if.sv
// Handshake bundle between the weight request-tracking FIFO, the DMA response
// port and the shared-buffer writer, as seen by the response sequencer.
interface nv_nvdla_cdma_wt_rsp_seq_if #(
   parameter int DW = 512
);
   logic          desc_vld;
   logic          desc_rdy;
   logic [5:0]    desc_len;
   logic          dma_rsp_vld;
   logic          dma_rsp_rdy;
   logic [DW-1:0] dma_rsp_data;
   logic          out_vld;
   logic          out_rdy;
   logic [DW-1:0] out_data;
   logic [5:0]    out_idx;
   logic          out_last;

   modport slave (
      input  desc_vld, desc_len, dma_rsp_vld, dma_rsp_data, out_rdy,
      output desc_rdy, dma_rsp_rdy, out_vld, out_data, out_idx, out_last
   );

   modport master (
      output desc_vld, desc_len, dma_rsp_vld, dma_rsp_data, out_rdy,
      input  desc_rdy, dma_rsp_rdy, out_vld, out_data, out_idx, out_last
   );
endinterface

// File: rtl/nv_nvdla_cdma_wt_rsp_seq.sv
// Pairs weight-read descriptors with in-order DMA response beats and emits each
// beat through a registered stage, tagged with its atom index and a last flag.
module nv_nvdla_cdma_wt_rsp_seq #(
   parameter int DW = 512
) (
   input  logic        clk,
   input  logic        reset_,
   input  logic        i_cnt_clr,
   output logic [31:0] o_atom_cnt,
   output logic        o_idle,
   nv_nvdla_cdma_wt_rsp_seq_if.slave bus
);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACTIVE = 1'b1
   } state_t;

   state_t        r_state;
   state_t        w_nextState;
   logic [5:0]    r_len;
   logic [5:0]    r_beatIdx;
   logic          r_outVld;
   logic [DW-1:0] r_outData;
   logic [5:0]    r_outIdx;
   logic          r_outLast;
   logic [31:0]   r_atomCnt;

   logic          w_rspRdy;
   logic          w_beatAcc;
   logic          w_lastBeat;
   logic          w_descRdy;
   logic          w_pop;
   logic          w_outHs;
   logic          w_idle;

   assign w_rspRdy   = (r_state == S_ACTIVE) && (!r_outVld || bus.out_rdy);
   assign w_beatAcc  = bus.dma_rsp_vld && w_rspRdy;
   assign w_lastBeat = (r_beatIdx == r_len);
   assign w_pop      = bus.desc_vld && w_descRdy;
   assign w_outHs    = r_outVld && bus.out_rdy;

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // A pop always wins, so a new request can start on the previous request's last beat.
   always_comb begin
      w_nextState = r_state;
      if (w_pop) begin
         w_nextState = S_ACTIVE;
      end else if ((r_state == S_ACTIVE) && w_beatAcc && w_lastBeat) begin
         w_nextState = S_IDLE;
      end
   end

   always_comb begin
      w_descRdy = 1'b0;
      w_idle    = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_descRdy = 1'b1;
            w_idle    = !r_outVld;
         end
         S_ACTIVE: begin
            w_descRdy = w_beatAcc && w_lastBeat;
         end
         default: begin
            w_descRdy = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_len     <= 6'd0;
         r_beatIdx <= 6'd0;
      end else if (w_pop) begin
         r_len     <= bus.desc_len;
         r_beatIdx <= 6'd0;
      end else if (w_beatAcc && !w_lastBeat) begin
         r_beatIdx <= r_beatIdx + 6'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_outVld  <= 1'b0;
         r_outIdx  <= 6'd0;
         r_outLast <= 1'b0;
      end else if (w_beatAcc) begin
         r_outVld  <= 1'b1;
         r_outIdx  <= r_beatIdx;
         r_outLast <= w_lastBeat;
      end else if (bus.out_rdy) begin
         r_outVld  <= 1'b0;
      end
   end

   // Payload is qualified by r_outVld, so it carries no reset.
   always_ff @(posedge clk) begin
      if (w_beatAcc) begin
         r_outData <= bus.dma_rsp_data;
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_atomCnt <= 32'd0;
      end else if (i_cnt_clr) begin
         r_atomCnt <= w_outHs ? 32'd1 : 32'd0;
      end else if (w_outHs) begin
         r_atomCnt <= r_atomCnt + 32'd1;
      end
   end

   assign bus.desc_rdy    = w_descRdy;
   assign bus.dma_rsp_rdy = w_rspRdy;
   assign bus.out_vld     = r_outVld;
   assign bus.out_data    = r_outData;
   assign bus.out_idx     = r_outIdx;
   assign bus.out_last    = r_outLast;
   assign o_atom_cnt      = r_atomCnt;
   assign o_idle          = w_idle;

endmodule

// File: tb/tb_nv_nvdla_cdma_wt_rsp_seq.sv
// Self-checking bench: descriptors expand into an expected tagged-beat stream
// which is compared against the beats the DUT hands downstream.
module tb_nv_nvdla_cdma_wt_rsp_seq;
   localparam int DW = 512;

   typedef struct {
      logic [DW-1:0] data;
      int            idx;
      bit            last;
      int            cyc;
   } beat_t;

   logic        clk = 1'b0;
   logic        reset_;
   logic        cnt_clr;
   logic [31:0] atom_cnt;
   logic        idle;

   nv_nvdla_cdma_wt_rsp_seq_if #(.DW(DW)) bus ();

   nv_nvdla_cdma_wt_rsp_seq #(.DW(DW)) dut (
      .clk       (clk),
      .reset_    (reset_),
      .i_cnt_clr (cnt_clr),
      .o_atom_cnt(atom_cnt),
      .o_idle    (idle),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int            descQ[$];
   logic [DW-1:0] rspQ[$];
   beat_t         expQ[$];
   beat_t         obsQ[$];
   bit            rdyPat[$];
   int            rdyPct, rspPct, descDelay, clrCycle;
   bit            logPop[$], logAcc[$], logRspRdy[$], logDescRdy[$], logVld[$], logHs[$];
   int            logIdx[$];

   function automatic logic [DW-1:0] randData();
      logic [DW-1:0] d;
      for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   // Each descriptor len expands to len+1 beats, indexed 0..len, payloads in arrival order.
   task automatic buildModel();
      foreach (descQ[k]) begin
         for (int i = 0; i <= descQ[k]; i++) begin
            beat_t b;
            b.data = randData();
            b.idx  = i;
            b.last = (i == descQ[k]);
            b.cyc  = 0;
            rspQ.push_back(b.data);
            expQ.push_back(b);
         end
      end
   endtask

   task automatic applyReset();
      bus.desc_vld     = 1'b0;
      bus.desc_len     = 6'd0;
      bus.dma_rsp_vld  = 1'b0;
      bus.dma_rsp_data = '0;
      bus.out_rdy      = 1'b0;
      cnt_clr          = 1'b0;
      rdyPct = 100; rspPct = 100; descDelay = 0; clrCycle = -1;
      descQ.delete(); rspQ.delete(); expQ.delete(); obsQ.delete(); rdyPat.delete();
      reset_ = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_ = 1'b1;
   endtask

   task automatic applyStimulus(input int budget);
      int cyc = 0;
      bit takeD = 0;
      bit takeR = 0;
      obsQ.delete();
      logPop.delete(); logAcc.delete(); logRspRdy.delete(); logDescRdy.delete();
      logVld.delete(); logHs.delete(); logIdx.delete();
      forever begin
         @(posedge clk); #1;
         if (takeD) void'(descQ.pop_front());
         if (takeR) void'(rspQ.pop_front());
         if (descQ.size() == 0 && rspQ.size() == 0 && obsQ.size() >= expQ.size() && !bus.out_vld) break;
         if (cyc >= budget) begin
            checks++; errors++;
            $display("[TB] FAIL timeout: %0d beats seen after %0d cycles, required %0d", obsQ.size(), cyc, expQ.size());
            break;
         end
         bus.desc_vld     = (cyc >= descDelay) && (descQ.size() > 0);
         bus.desc_len     = (descQ.size() > 0) ? 6'(descQ[0]) : 6'd0;
         bus.dma_rsp_vld  = (rspQ.size() > 0) && ($urandom_range(99) < rspPct);
         bus.dma_rsp_data = (rspQ.size() > 0) ? rspQ[0] : '0;
         bus.out_rdy      = (rdyPat.size() > 0) ? rdyPat.pop_front() : ($urandom_range(99) < rdyPct);
         cnt_clr          = (cyc == clrCycle);
         @(negedge clk);
         takeD = bus.desc_vld && bus.desc_rdy;
         takeR = bus.dma_rsp_vld && bus.dma_rsp_rdy;
         logPop.push_back(takeD);
         logAcc.push_back(takeR);
         logRspRdy.push_back(bus.dma_rsp_rdy);
         logDescRdy.push_back(bus.desc_rdy);
         logVld.push_back(bus.out_vld);
         logHs.push_back(bus.out_vld && bus.out_rdy);
         logIdx.push_back(int'(bus.out_idx));
         if (bus.out_vld && bus.out_rdy) begin
            beat_t b;
            b.data = bus.out_data;
            b.idx  = int'(bus.out_idx);
            b.last = bus.out_last;
            b.cyc  = cyc;
            obsQ.push_back(b);
         end
         cyc++;
      end
      bus.desc_vld = 1'b0; bus.dma_rsp_vld = 1'b0; bus.out_rdy = 1'b0; cnt_clr = 1'b0;
   endtask

   task automatic test_reset();
      bus.out_rdy = 1'b0; bus.desc_vld = 1'b0; bus.dma_rsp_vld = 1'b0; cnt_clr = 1'b0;
      reset_ = 1'b0;
      #3;
      checks++; if (bus.desc_rdy !== 1'b1)    begin errors++; $display("[TB] FAIL rst_desc_rdy: got %b, expected 1", bus.desc_rdy); end
      checks++; if (bus.dma_rsp_rdy !== 1'b0) begin errors++; $display("[TB] FAIL rst_rsp_rdy: got %b, expected 0", bus.dma_rsp_rdy); end
      checks++; if (bus.out_vld !== 1'b0)     begin errors++; $display("[TB] FAIL rst_out_vld: got %b, expected 0", bus.out_vld); end
      checks++; if (bus.out_idx !== 6'd0)     begin errors++; $display("[TB] FAIL rst_out_idx: got %0d, expected 0", bus.out_idx); end
      checks++; if (bus.out_last !== 1'b0)    begin errors++; $display("[TB] FAIL rst_out_last: got %b, expected 0", bus.out_last); end
      checks++; if (atom_cnt !== 32'd0)       begin errors++; $display("[TB] FAIL rst_atom_cnt: got %0d, expected 0", atom_cnt); end
      checks++; if (idle !== 1'b1)            begin errors++; $display("[TB] FAIL rst_idle: got %b, expected 1", idle); end
      applyReset();
   endtask

   task automatic test_single();
      applyReset();
      descQ.push_back(0);
      buildModel();
      applyStimulus(50);
      checks++; if (obsQ.size() != 1) begin errors++; $display("[TB] FAIL single_count: got %0d beats, expected 1", obsQ.size()); end
      for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
         checks++;
         if (obsQ[i].data !== expQ[i].data || obsQ[i].idx != expQ[i].idx || obsQ[i].last != expQ[i].last) begin
            errors++; $display("[TB] FAIL single_beat%0d: got idx=%0d last=%0b data[31:0]=%h, expected idx=%0d last=%0b data[31:0]=%h",
               i, obsQ[i].idx, obsQ[i].last, obsQ[i].data[31:0], expQ[i].idx, expQ[i].last, expQ[i].data[31:0]);
         end
      end
      checks++; if (atom_cnt !== 32'd1) begin errors++; $display("[TB] FAIL single_atom_cnt: got %0d, expected 1", atom_cnt); end
      checks++; if (idle !== 1'b1)      begin errors++; $display("[TB] FAIL single_idle: got %b, expected 1", idle); end
   endtask

   task automatic test_four_beat();
      int k = 0;
      applyReset();
      descQ.push_back(3);
      buildModel();
      applyStimulus(50);
      checks++; if (obsQ.size() != 4) begin errors++; $display("[TB] FAIL four_count: got %0d beats, expected 4", obsQ.size()); end
      for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
         checks++;
         if (obsQ[i].data !== expQ[i].data || obsQ[i].idx != expQ[i].idx || obsQ[i].last != expQ[i].last || obsQ[i].cyc != obsQ[0].cyc + i) begin
            errors++; $display("[TB] FAIL four_beat%0d: got idx=%0d last=%0b cyc=%0d, expected idx=%0d last=%0b cyc=%0d",
               i, obsQ[i].idx, obsQ[i].last, obsQ[i].cyc, expQ[i].idx, expQ[i].last, obsQ[0].cyc + i);
         end
      end
      foreach (logAcc[c]) begin
         if (logAcc[c]) begin
            checks++;
            if (logDescRdy[c] != (k == 3)) begin
               errors++; $display("[TB] FAIL four_desc_rdy: accept %0d got desc_rdy=%0b, expected %0b", k, logDescRdy[c], (k == 3));
            end
            k++;
         end
      end
   endtask

   task automatic test_back_to_back();
      applyReset();
      descQ.push_back(1);
      descQ.push_back(2);
      buildModel();
      applyStimulus(60);
      checks++; if (obsQ.size() != 5) begin errors++; $display("[TB] FAIL b2b_count: got %0d beats, expected 5", obsQ.size()); end
      for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
         checks++;
         if (obsQ[i].data !== expQ[i].data || obsQ[i].idx != expQ[i].idx || obsQ[i].last != expQ[i].last || obsQ[i].cyc != obsQ[0].cyc + i) begin
            errors++; $display("[TB] FAIL b2b_beat%0d: got idx=%0d last=%0b cyc=%0d, expected idx=%0d last=%0b cyc=%0d",
               i, obsQ[i].idx, obsQ[i].last, obsQ[i].cyc, expQ[i].idx, expQ[i].last, obsQ[0].cyc + i);
         end
      end
   endtask

   task automatic test_output_stall();
      applyReset();
      descQ.push_back(2);
      buildModel();
      rdyPat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      applyStimulus(60);
      for (int c = 2; c <= 4 && c < logVld.size(); c++) begin
         checks++;
         if (logVld[c] != 1'b1 || logIdx[c] != 0 || logRspRdy[c] != 1'b0) begin
            errors++; $display("[TB] FAIL stall_cyc%0d: got out_vld=%0b idx=%0d rsp_rdy=%0b, expected out_vld=1 idx=0 rsp_rdy=0",
               c, logVld[c], logIdx[c], logRspRdy[c]);
         end
      end
      checks++; if (obsQ.size() != 3) begin errors++; $display("[TB] FAIL stall_count: got %0d beats, expected 3", obsQ.size()); end
      for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
         checks++;
         if (obsQ[i].data !== expQ[i].data || obsQ[i].idx != expQ[i].idx || obsQ[i].last != expQ[i].last) begin
            errors++; $display("[TB] FAIL stall_beat%0d: got idx=%0d last=%0b, expected idx=%0d last=%0b",
               i, obsQ[i].idx, obsQ[i].last, expQ[i].idx, expQ[i].last);
         end
      end
      checks++; if (atom_cnt !== 32'd3) begin errors++; $display("[TB] FAIL stall_atom_cnt: got %0d, expected 3", atom_cnt); end
   endtask

   task automatic test_beats_before_desc();
      applyReset();
      descQ.push_back(0);
      buildModel();
      descDelay = 4;
      applyStimulus(50);
      for (int c = 0; c < 4 && c < logRspRdy.size(); c++) begin
         checks++;
         if (logRspRdy[c] != 1'b0) begin errors++; $display("[TB] FAIL early_rsp_rdy_cyc%0d: got 1, expected 0", c); end
      end
      if (logAcc.size() > 5) begin
         checks++;
         if (logPop[4] != 1'b1 || logAcc[4] != 1'b0 || logAcc[5] != 1'b1) begin
            errors++; $display("[TB] FAIL early_latency: got pop4=%0b acc4=%0b acc5=%0b, expected 1 0 1", logPop[4], logAcc[4], logAcc[5]);
         end
      end else begin
         checks++; errors++; $display("[TB] FAIL early_latency: run ended after %0d cycles, expected at least 6", logAcc.size());
      end
      checks++; if (obsQ.size() != 1 || (obsQ.size() == 1 && obsQ[0].data !== expQ[0].data)) begin
         errors++; $display("[TB] FAIL early_beat: got %0d beats, expected 1 with matching data", obsQ.size());
      end
   endtask

   task automatic test_full_length_clr();
      applyReset();
      descQ.push_back(63);
      buildModel();
      clrCycle = 12;
      applyStimulus(200);
      checks++; if (obsQ.size() != 64) begin errors++; $display("[TB] FAIL full_count: got %0d beats, expected 64", obsQ.size()); end
      for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
         checks++;
         if (obsQ[i].data !== expQ[i].data || obsQ[i].idx != expQ[i].idx || obsQ[i].last != expQ[i].last) begin
            errors++; $display("[TB] FAIL full_beat%0d: got idx=%0d last=%0b, expected idx=%0d last=%0b",
               i, obsQ[i].idx, obsQ[i].last, expQ[i].idx, expQ[i].last);
         end
      end
      checks++;
      if (logHs.size() <= 12 || logHs[12] != 1'b1 || logIdx[12] != 10) begin
         errors++; $display("[TB] FAIL full_clr_align: clear cycle did not coincide with handshake of idx 10");
      end
      checks++; if (atom_cnt !== 32'd54) begin errors++; $display("[TB] FAIL full_atom_cnt: got %0d, expected 54", atom_cnt); end
   endtask

   task automatic test_random();
      int total;
      for (int r = 0; r < 3; r++) begin
         applyReset();
         for (int k = 0; k < 6; k++) descQ.push_back($urandom_range(0, 15));
         buildModel();
         total = expQ.size();
         rdyPct = 60;
         rspPct = 70;
         applyStimulus(2000);
         checks++; if (obsQ.size() != total) begin errors++; $display("[TB] FAIL rand%0d_count: got %0d beats, expected %0d", r, obsQ.size(), total); end
         for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
            checks++;
            if (obsQ[i].data !== expQ[i].data || obsQ[i].idx != expQ[i].idx || obsQ[i].last != expQ[i].last) begin
               errors++; $display("[TB] FAIL rand%0d_beat%0d: got idx=%0d last=%0b data[31:0]=%h, expected idx=%0d last=%0b data[31:0]=%h",
                  r, i, obsQ[i].idx, obsQ[i].last, obsQ[i].data[31:0], expQ[i].idx, expQ[i].last, expQ[i].data[31:0]);
            end
         end
         checks++; if (atom_cnt !== 32'(total)) begin errors++; $display("[TB] FAIL rand%0d_atom_cnt: got %0d, expected %0d", r, atom_cnt, total); end
         checks++; if (idle !== 1'b1) begin errors++; $display("[TB] FAIL rand%0d_idle: got %b, expected 1", r, idle); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_four_beat();
      test_back_to_back();
      test_output_stall();
      test_beats_before_desc();
      test_full_length_clr();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nv_nvdla_cdma_wt_rsp_seq.md
# nv_nvdla_cdma_wt_rsp_seq

Read-side consumer of the CDMA weight request-tracking FIFO. Each FIFO entry is a 6-bit descriptor that gives the atom count of one outstanding weight DMA read. This block pops descriptors, pairs each with the matching in-order DMA response beats, and tags every beat with its atom index and a last flag. It sends tagged beats through a registered output stage toward the weight shared-buffer writer.

## Interface
- DW, 512, DMA response / output data width (one atom per beat)
- clk  input  1  core clock
- reset_  input  1  asynchronous, active-low reset
- desc_vld  input  1  descriptor available (FIFO rd_req)
- desc_rdy  output  1  descriptor pop (FIFO rd_ready)
- desc_len  input  6  atoms-1 of request (FIFO rd_data), range 0..63
- dma_rsp_vld  input  1  response beat valid
- dma_rsp_rdy  output  1  response beat accepted
- dma_rsp_data  input  DW  response beat payload
- out_vld  output  1  tagged beat valid
- out_rdy  input  1  downstream accept
- out_data  output  DW  beat payload
- out_idx  output  6  atom index within request
- out_last  output  1  final beat of request
- cnt_clr  input  1  synchronous clear of atom_cnt
- atom_cnt  output  32  total atoms delivered on output, wraps
- idle  output  1  IDLE state and out_vld==0

## Operation
- States: IDLE and ACTIVE. Reset state is IDLE.
- Registers held while ACTIVE:
  - len_r: 6 bits, the latched desc_len.
  - beat_idx: 6 bits, the index of the next expected beat.
- Descriptor pop: desc_rdy = (state==IDLE) || (state==ACTIVE && beat_acc && beat_idx==len_r).
  - This lets a new descriptor load in the same cycle as the last beat of the previous request, with no bubble.
  - This creates a combinational path from dma_rsp_vld and out_rdy to desc_rdy, and that path is intentional.
- Pop action (desc_vld && desc_rdy): len_r <= desc_len, beat_idx <= 0, state <= ACTIVE.
- Last-beat accept with no pop: state <= IDLE.
- Beat accept:
  - beat_acc = dma_rsp_vld && dma_rsp_rdy.
  - dma_rsp_rdy = (state==ACTIVE) && (!out_vld || out_rdy).
  - In IDLE, dma_rsp_rdy is 0. Response beats that arrive with no descriptor are stalled, never dropped.
- On beat_acc:
  - out_data <= dma_rsp_data, out_idx <= beat_idx, out_last <= (beat_idx==len_r), out_vld <= 1.
  - If not last, beat_idx <= beat_idx+1.
- Output register:
  - out_vld clears when out_rdy && !beat_acc.
  - out_data, out_idx and out_last hold stable while out_vld && !out_rdy.
- atom_cnt: increments by 1 on each output handshake (out_vld && out_rdy), 32-bit modulo.
  - cnt_clr alone sets it to 0.
  - cnt_clr together with a handshake sets it to 1.
- idle = (state==IDLE) && !out_vld.

## Timing
- Reset values:
  - desc_rdy=1, because IDLE forces it high.
  - dma_rsp_rdy=0, out_vld=0, out_idx=0, out_last=0, atom_cnt=0, idle=1.
  - out_data is not reset.
- Latency: a beat accepted in cycle N appears on out_* in cycle N+1.
  - Sustained throughput is 1 beat/cycle with out_rdy=1, including across request boundaries.
- First beat of a request: it can be accepted at earliest the cycle after the descriptor pop.
  - The pop moves state to ACTIVE at the edge, so a response beat pending at pop time waits one cycle.
- Backpressure: with out_vld=1 and out_rdy=0, dma_rsp_rdy=0, and beat_idx and state freeze.
- desc_len=0: single-beat request. The first beat has out_last=1 and out_idx=0.
- desc_len=63: indices 0..63. beat_idx never wraps, because the last beat does not increment it.
- Reset mid-request:
  - State, len_r, beat_idx and the output register clear immediately (asynchronous).
  - The partially consumed descriptor is lost.
  - Upstream FIFO and DMA reset together with this block.

## Test plan
- Single short request: reset, then desc_len=0 and one beat data=A with out_rdy=1. Required response: one output cycle with out_data=A, out_idx=0, out_last=1; atom_cnt=1; idle=1 two cycles later.
- Four-beat request: desc_len=3 with 4 contiguous beats. Required response: out_idx=0,1,2,3 on consecutive cycles; out_last only on idx 3; desc_rdy=1 in the last-beat accept cycle.
- Back-to-back requests: descriptors 1 then 2 queued, with 5 contiguous beats. Required response: out_idx sequence 0,1,0,1,2 with no bubble; out_last on the 2nd and 5th beats.
- Output stall: desc_len=2 with out_rdy held low for 3 cycles after the first output. Required response: output held at idx 0; dma_rsp_rdy=0 during the stall; all 3 beats delivered in order; atom_cnt=3.
- Beats before descriptor: dma_rsp_vld=1 for 4 cycles with desc_vld=0. Required response: dma_rsp_rdy=0 throughout; after desc_len=0 arrives, the beat is accepted one cycle after the pop.
- Full-length request with counter clear: desc_len=63, then cnt_clr pulsed during the handshake of idx 10. Required response: out_idx 0..63 with out_last at 63; final atom_cnt=54.
